// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter slice.
// Write-size encoding, FSM states and a write-detect helper.
package dmem_arb_pkg;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_BYTE = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_WORD = 2'b11;

  localparam int unsigned LOCK_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } dmem_arb_state_t;

  function automatic logic is_wr(input logic [1:0] wr);
    return wr inside {WR_BYTE, WR_HALF, WR_WORD};
  endfunction

endpackage

// File: rtl/dmem_arb_lock_timer.sv
// Lock watchdog: counts cycles spent in a lock state and
// flags the cycle that reaches LOCK_MAX.
module dmem_arb_lock_timer #(
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  import dmem_arb_pkg::*;

  localparam logic [LOCK_W-1:0] LAST = LOCK_W'(LOCK_MAX - 1);

  logic [LOCK_W-1:0] cnt_q;
  logic [LOCK_W-1:0] cnt_d;

  // Fires on the LOCK_MAX-th consecutive lock cycle.
  assign expired_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with optional bus lock.
// Define DMEM_ARB_RR_EN for round-robin ties, else port 0 wins.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [1:0]  req0_wr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_lock,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [1:0]  req1_wr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_lock,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  mem_wr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        owner,
  output logic        lock_timeout
);
  import dmem_arb_pkg::*;

  dmem_arb_state_t state_q, state_d;

  logic        win0;
  logic        acc0, acc1, acc;
  logic        expired;
  logic        tmr_clear, tmr_en;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_wr;
  logic        sel_lock;
  logic        owner_q, to_q;
  logic        pend0_q, pend1_q;
  logic [31:0] hold0_q, hold1_q;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // last_q=1 means port 1 was served last, so port 0 wins a tie.
  assign win0 = last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (acc) begin
      last_q <= acc1;
    end
  end
`else
  assign win0 = 1'b1;
`endif

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          req0_ready = req0_valid && (!req1_valid || win0);
          req1_ready = req1_valid && (!req0_valid || !win0);
        end
        LOCK0:   req0_ready = req0_valid;
        LOCK1:   req1_ready = req1_valid;
        default: ;
      endcase
    end
  end

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign acc  = acc0 || acc1;

  always_comb begin
    sel_addr  = '0;
    sel_wr    = WR_NONE;
    sel_wdata = '0;
    sel_lock  = 1'b0;
    unique case (1'b1)
      acc0: begin
        sel_addr  = req0_addr;
        sel_wr    = req0_wr;
        sel_wdata = req0_wdata;
        sel_lock  = req0_lock;
      end
      acc1: begin
        sel_addr  = req1_addr;
        sel_wr    = req1_wr;
        sel_wdata = req1_wdata;
        sel_lock  = req1_lock;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_rd_addr = '0;
    mem_wr      = WR_NONE;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (is_wr(sel_wr)) begin
      mem_wr      = sel_wr;
      mem_wr_addr = sel_addr;
      mem_wr_data = sel_wdata;
    end else if (acc) begin
      mem_rd_addr = sel_addr;
    end
  end

  // Watchdog expiry wins over the lock bit of a same-cycle request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc && sel_lock) begin
          state_d = acc1 ? LOCK1 : LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        if (expired || (acc && !sel_lock)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tmr_en    = (state_q != IDLE);
  assign tmr_clear = (state_q == IDLE) || (state_d == IDLE);

  dmem_arb_lock_timer #(
    .LOCK_MAX (LOCK_MAX)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      to_q    <= 1'b0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= expired;
      pend0_q <= acc0 && !is_wr(req0_wr);
      pend1_q <= acc1 && !is_wr(req1_wr);
      if (acc) begin
        owner_q <= acc1;
      end
      if (pend0_q) begin
        hold0_q <= mem_rd_data;
      end
      if (pend1_q) begin
        hold1_q <= mem_rd_data;
      end
    end
  end

  // Memory data arrives a cycle after the address; pass it
  // straight through and keep a copy for the idle cycles.
  assign rsp0_valid   = pend0_q && rst_n;
  assign rsp1_valid   = pend1_q && rst_n;
  assign rsp0_rdata   = rsp0_valid ? mem_rd_data : hold0_q;
  assign rsp1_rdata   = rsp1_valid ? mem_rd_data : hold1_q;
  assign owner        = owner_q;
  assign lock_timeout = to_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a write-first memory.
// Expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] D10 = 32'hDEADBEEF;
  localparam logic [31:0] D14 = 32'hCAFEF00D;
  localparam logic [31:0] D18 = 32'h0BADF00D;
  localparam logic [31:0] DW  = 32'h12345678;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic [1:0]  req0_wr;
  logic        req1_valid, req1_ready, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic [1:0]  req1_wr;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic [1:0]  mem_wr;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        owner, lock_timeout;

  dmem_arbiter #(.LOCK_MAX(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_wr      (req0_wr),
    .req0_wdata   (req0_wdata),
    .req0_lock    (req0_lock),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_wr      (req1_wr),
    .req1_wdata   (req1_wdata),
    .req1_lock    (req1_lock),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr       (mem_wr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .owner        (owner),
    .lock_timeout (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:255];
  logic [31:0] mrd_q;
  assign mem_rd_data = mrd_q;

  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    logic [7:0]  wi, ri;
    wi = mem_wr_addr[9:2];
    ri = mem_rd_addr[9:2];
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4] <= D10;
      mem[5] <= D14;
      mem[6] <= D18;
      mrd_q  <= 32'h0;
    end else begin
      w = mem[wi];
      case (mem_wr)
        WR_BYTE: w[{mem_wr_addr[1:0], 3'b000} +: 8] = mem_wr_data[7:0];
        WR_HALF: w[{mem_wr_addr[1], 4'b0000} +: 16] = mem_wr_data[15:0];
        WR_WORD: w = mem_wr_data;
        default: ;
      endcase
      if (mem_wr != WR_NONE) mem[wi] <= w;
      mrd_q <= (mem_wr != WR_NONE && wi == ri) ? w : mem[ri];
    end
  end

  typedef struct {
    int          cyc;
    int          port;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rexp_t;

  typedef struct {
    bit          v0, l0, v1, l1;
    logic [31:0] a0, a1, wd, rd;
    logic [1:0]  w0, w1;
    int          g;
    bit          to, drop;
  } vec_t;

  gexp_t gq[$];
  rexp_t rq0[$], rq1[$];
  int    toq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: event with no expectation", name, cyc);
  endtask

  function automatic vec_t mk(
    bit v0, logic [31:0] a0, logic [1:0] w0, bit l0,
    bit v1, logic [31:0] a1, logic [1:0] w1, bit l1,
    logic [31:0] wd, int g, logic [31:0] rd, bit to, bit drop);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.w0 = w0; v.l0 = l0;
    v.v1 = v1; v.a1 = a1; v.w1 = w1; v.l1 = l1;
    v.wd = wd; v.g = g; v.rd = rd; v.to = to; v.drop = drop;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, WR_NONE, 0, 0, 0, WR_NONE, 0, 0, -1, 0, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    gexp_t e;
    rexp_t r;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req0_valid = v.v0; req0_addr = v.a0; req0_wr = v.w0;
    req0_lock  = v.l0; req0_wdata = v.wd;
    req1_valid = v.v1; req1_addr = v.a1; req1_wr = v.w1;
    req1_lock  = v.l1; req1_wdata = v.wd;
    if (v.g == 0 || v.g == 1) begin
      e.cyc   = cyc;
      e.port  = v.g;
      e.wr    = (v.g == 1) ? v.w1 : v.w0;
      e.addr  = (v.g == 1) ? v.a1 : v.a0;
      e.wdata = v.wd;
      gq.push_back(e);
      if (e.wr == WR_NONE && !v.drop) begin
        r.cyc  = cyc + 1;
        r.data = v.rd;
        if (v.g == 1) rq1.push_back(r);
        else          rq0.push_back(r);
      end
    end
    if (v.to) toq.push_back(cyc);
  endtask

  task automatic chk_reset();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_rsp1_rdata", rsp1_rdata, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_lock_timeout", lock_timeout, 0);
  endtask

  int          own_exp = 0;
  bit          own_chk = 0;
  bit          hold_ok = 0;
  logic [31:0] h0 = 0, h1 = 0;

  always @(negedge clk) begin : monitor
    gexp_t e;
    rexp_t r;
    bit    a0, a1;
    if (own_chk) chk("owner", owner, own_exp);
    own_chk = 0;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (a0 && a1) fail("double_grant");
    if (a0 || a1) begin
      if (gq.size() == 0) begin
        fail("unexpected_grant");
      end else begin
        e = gq.pop_front();
        chk("grant_cycle", cyc, e.cyc);
        chk("grant_port", a1, e.port);
        if (e.wr == WR_NONE) begin
          chk("mem_rd_addr", mem_rd_addr, e.addr);
          chk("mem_wr_none", mem_wr, WR_NONE);
        end else begin
          chk("mem_wr", mem_wr, e.wr);
          chk("mem_wr_addr", mem_wr_addr, e.addr);
          chk("mem_wr_data", mem_wr_data, e.wdata);
        end
        own_exp = e.port;
        own_chk = 1;
      end
    end else begin
      chk("mem_idle", mem_wr == 0 && mem_rd_addr == 0 &&
          mem_wr_addr == 0 && mem_wr_data == 0, 1);
    end
    if (rsp0_valid) begin
      if (rq0.size() == 0) fail("unexpected_rsp0");
      else begin
        r = rq0.pop_front();
        chk("rsp0_cycle", cyc, r.cyc);
        chk("rsp0_rdata", rsp0_rdata, r.data);
        h0 = r.data;
      end
    end else if (hold_ok) begin
      chk("rsp0_hold", rsp0_rdata, h0);
    end
    if (rsp1_valid) begin
      if (rq1.size() == 0) fail("unexpected_rsp1");
      else begin
        r = rq1.pop_front();
        chk("rsp1_cycle", cyc, r.cyc);
        chk("rsp1_rdata", rsp1_rdata, r.data);
        h1 = r.data;
      end
    end else if (hold_ok) begin
      chk("rsp1_hold", rsp1_rdata, h1);
    end
    if (lock_timeout) begin
      if (toq.size() == 0) fail("unexpected_timeout");
      else chk("timeout_cycle", cyc, toq.pop_front());
    end
    if (!rst_n) begin
      hold_ok = 0;
      h0 = 0;
      h1 = 0;
    end else begin
      hold_ok = 1;
    end
  end

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'h10; req0_wr = WR_NONE;
    req0_lock  = 1'b0; req0_wdata = 0;
    req1_valid = 1'b1; req1_addr = 32'h14; req1_wr = WR_NONE;
    req1_lock  = 1'b0; req1_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();

    // both ports read every cycle straight out of reset
    for (int i = 0; i < 4; i++) begin
      int g;
      g = RR ? (i % 2) : 0;
      drive(mk(1, 32'h10, WR_NONE, 0, 1, 32'h14, WR_NONE, 0,
               0, g, g ? D14 : D10, 0, 0));
    end
    drive(idle());

    // single read from port 0
    drive(mk(1, 32'h10, WR_NONE, 0, 0, 0, WR_NONE, 0,
             0, 0, D10, 0, 0));
    drive(idle());
    drive(idle());

    // port 1 locked write then read-back while port 0 waits
    drive(mk(RR, 32'h10, WR_NONE, 0, 1, 32'h40, WR_WORD, 1,
             DW, 1, 0, 0, 0));
    drive(mk(1, 32'h10, WR_NONE, 0, 1, 32'h40, WR_NONE, 0,
             0, 1, DW, 0, 0));
    drive(mk(1, 32'h10, WR_NONE, 0, 0, 0, WR_NONE, 0,
             0, 0, D10, 0, 0));
    drive(idle());

    // port 0 locks then idles until the watchdog fires
    drive(mk(1, 32'h18, WR_NONE, 1, 0, 0, WR_NONE, 0,
             0, 0, D18, 0, 0));
    repeat (15)
      drive(mk(0, 0, WR_NONE, 0, 1, 32'h14, WR_NONE, 0,
               0, -1, 0, 0, 0));
    drive(mk(0, 0, WR_NONE, 0, 1, 32'h14, WR_NONE, 0,
             0, 1, D14, 1, 0));
    drive(idle());
    drive(idle());

    // reset right after a read is accepted drops the response
    drive(mk(1, 32'h10, WR_NONE, 0, 0, 0, WR_NONE, 0,
             0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'h10; req0_wr = WR_NONE;
    req1_valid = 1'b1; req1_addr = 32'h14; req1_wr = WR_NONE;
    @(negedge clk);
    chk("rsp0_dropped", rsp0_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    drive(mk(1, 32'h10, WR_NONE, 0, 1, 32'h14, WR_NONE, 0,
             0, 0, D10, 0, 0));
    drive(mk(1, 32'h10, WR_NONE, 0, 1, 32'h14, WR_NONE, 0,
             0, RR ? 1 : 0, RR ? D14 : D10, 0, 0));
    drive(idle());
    drive(idle());
    @(posedge clk);
    @(negedge clk);

    chk("grants_left", gq.size(), 0);
    chk("rsp0_left", rq0.size(), 0);
    chk("rsp1_left", rq1.size(), 0);
    chk("timeouts_left", toq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
